dma_adma_ctrl: RTL and testbench
================================

DMA_ADMA_CTRL -- requirements
Module: dma_adma_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, begin descriptor processing at desc_base; sampled only in ST_STOP.
REQ-004 SHALL have port abort, input, 1, synchronous stop request; highest priority after reset.
REQ-005 SHALL have port desc_base, input, 64, system address of the first descriptor.
REQ-006 SHALL have port fetch_ack, input, 1, descriptor fields valid this cycle.
REQ-007 SHALL have ports valid_IN, End_IN, act1_IN, act2_IN, input, 1 each, attribute bits of the fetched descriptor.
REQ-008 SHALL have port len_IN, input, 16, descriptor length in bytes; bits [1:0] ignored; 0 means 65536.
REQ-009 SHALL have port addr_COM, input, 64, descriptor address field (data or link address).
REQ-010 SHALL have port xfer_ack, input, 1, one 4-byte word moved this cycle.
REQ-011 SHALL have port fetch_req, output, 1, descriptor fetch request.
REQ-012 SHALL have port xfer_req, output, 1, data word transfer request.
REQ-013 SHALL have port addr_RAM, output, 64, descriptor pointer in ST_FDS, data address in ST_TFR, else 0.
REQ-014 SHALL have ports valid_OUT, End_OUT, output, 1 each, latched valid/End attributes of the current descriptor.
REQ-015 SHALL have port trans, output, 2, state: 00 ST_STOP, 01 ST_FDS, 10 ST_CADR, 11 ST_TFR.
REQ-016 SHALL have ports done, error, output, 1 each; done is a 1-cycle pulse, error is sticky.

Function
REQ-017 SHALL, in ST_STOP with start=1, load desc_ptr<=desc_base, clear error, and enter ST_FDS next cycle; start SHALL be ignored in any other state.
REQ-018 SHALL, in ST_FDS, hold fetch_req=1 and addr_RAM=desc_ptr until fetch_ack=1; fetch_req SHALL deassert the cycle after the acknowledge.
REQ-019 SHALL, on fetch_ack, latch valid_IN, End_IN, {act2_IN,act1_IN}, len_IN, addr_COM into internal registers; valid_OUT and End_OUT SHALL show the latched values from the next cycle.
REQ-020 SHALL, when the latched valid=0, enter ST_STOP and set error=1, with no done pulse.
REQ-021 SHALL, when valid=1, enter ST_CADR for exactly one cycle and advance desc_ptr by 16, modulo 2^64.
REQ-022 SHALL decode act {act2,act1}: 00 nop, 01 reserved (treated as nop), 10 tran, 11 link.
REQ-023 SHALL, for tran, load data_addr<=addr_COM and remaining<=len (17-bit, 0 maps to 65536, rounded down to a multiple of 4), then enter ST_TFR.
REQ-024 SHALL, for link, load desc_ptr<=addr_COM instead of desc_ptr+16.
REQ-025 SHALL, for nop or link, enter ST_STOP with a done pulse if End=1, else ST_FDS.
REQ-026 SHALL, in ST_TFR, hold xfer_req=1 and addr_RAM=data_addr; each xfer_ack SHALL add 4 to data_addr (mod 2^64) and subtract 4 from remaining.
REQ-027 SHALL, on the xfer_ack that brings remaining to 0, deassert xfer_req the next cycle and enter ST_STOP with a done pulse if End=1, else ST_FDS.
REQ-028 SHALL, for a tran with len_IN in 1..3 (rounds to 0 bytes), skip ST_TFR and take the REQ-025 path.
REQ-029 SHALL, when abort=1 in any state, enter ST_STOP next cycle with fetch_req=xfer_req=0, no done pulse, and error unchanged; abort and start together in ST_STOP SHALL leave the block in ST_STOP.
REQ-030 SHALL ignore fetch_ack outside ST_FDS and xfer_ack outside ST_TFR.

Reset
REQ-031 SHALL, while reset=1, immediately force trans=00, fetch_req=0, xfer_req=0, addr_RAM=0, valid_OUT=0, End_OUT=0, done=0, error=0, desc_ptr=0, data_addr=0, remaining=0, regardless of clk.
REQ-032 SHALL, on reset asserted mid-transfer, discard the remaining count; the first action after release SHALL be a start in ST_STOP.

Verification
REQ-033 Single tran: desc_base=0x1000, fetch {valid=1,End=1,act=10,len=8,addr_COM=0x00000BBB00000000} -> two xfer_req cycles at 0x00000BBB00000000 and 0x00000BBB00000004, then trans=00 and done=1 for 1 cycle.
REQ-034 Link chain: desc0 {valid=1,End=0,act=11,addr_COM=0x2000}, desc1 {valid=1,End=1,act=10,len=4,addr_COM=0xAAAA00} -> second fetch at addr_RAM=0x2000; one transfer at 0xAAAA00; done.
REQ-035 Invalid descriptor: fetch with valid=0 -> ST_STOP next cycle, error=1, done=0; next start clears error.
REQ-036 len_IN=0 -> 16384 xfer_acks accepted before exit; data_addr ends at start+0x10000.
REQ-037 Abort during ST_TFR after 2 acks -> trans=00 next cycle, xfer_req=0, no done; reset asserted mid-fetch -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/dma_adma_ctrl.sv
// ADMA-style descriptor walker: fetches 16-byte descriptors, follows links and
// issues word-granular data transfer requests for tran descriptors.
module dma_adma_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [63:0] desc_base,
   input  logic        fetch_ack,
   input  logic        valid_IN,
   input  logic        End_IN,
   input  logic        act1_IN,
   input  logic        act2_IN,
   input  logic [15:0] len_IN,
   input  logic [63:0] addr_COM,
   input  logic        xfer_ack,
   output logic        fetch_req,
   output logic        xfer_req,
   output logic [63:0] addr_RAM,
   output logic        valid_OUT,
   output logic        End_OUT,
   output logic [1:0]  trans,
   output logic        done,
   output logic        error
);

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_FDS  = 2'b01,
      ST_CADR = 2'b10,
      ST_TFR  = 2'b11
   } state_t;

   state_t      state_r;
   logic [63:0] desc_ptr_r;
   logic [63:0] data_addr_r;
   logic [63:0] addr_lat_r;
   logic [16:0] remaining_r;
   logic [1:0]  act_r;
   logic [13:0] len_words_r;
   logic        len_zero_r;

   logic [16:0] len_bytes_s;
   logic [63:0] next_ptr_s;
   logic [63:0] data_next_s;

   // A zero length field encodes 65536 bytes; the low two bits never count.
   assign len_bytes_s = len_zero_r ? 17'h10000 : {1'b0, len_words_r, 2'b00};
   assign next_ptr_s  = (act_r == 2'b11) ? addr_lat_r : (desc_ptr_r + 64'd16);
   assign data_next_s = data_addr_r + 64'd4;
   assign trans       = state_r;

   // Descriptor walker state machine with registered request/address outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_STOP;
         desc_ptr_r  <= 64'd0;
         data_addr_r <= 64'd0;
         addr_lat_r  <= 64'd0;
         remaining_r <= 17'd0;
         act_r       <= 2'b00;
         len_words_r <= 14'd0;
         len_zero_r  <= 1'b0;
         fetch_req   <= 1'b0;
         xfer_req    <= 1'b0;
         addr_RAM    <= 64'd0;
         valid_OUT   <= 1'b0;
         End_OUT     <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state_r   <= ST_STOP;
            fetch_req <= 1'b0;
            xfer_req  <= 1'b0;
            addr_RAM  <= 64'd0;
         end else begin
            case (state_r)
               ST_STOP: begin
                  if (start) begin
                     desc_ptr_r <= desc_base;
                     error      <= 1'b0;
                     state_r    <= ST_FDS;
                     fetch_req  <= 1'b1;
                     addr_RAM   <= desc_base;
                  end
               end
               ST_FDS: begin
                  if (fetch_ack) begin
                     valid_OUT   <= valid_IN;
                     End_OUT     <= End_IN;
                     act_r       <= {act2_IN, act1_IN};
                     len_words_r <= len_IN[15:2];
                     len_zero_r  <= (len_IN == 16'd0);
                     addr_lat_r  <= addr_COM;
                     fetch_req   <= 1'b0;
                     addr_RAM    <= 64'd0;
                     if (valid_IN) begin
                        state_r <= ST_CADR;
                     end else begin
                        state_r <= ST_STOP;
                        error   <= 1'b1;
                     end
                  end
               end
               ST_CADR: begin
                  desc_ptr_r <= next_ptr_s;
                  // A tran that rounds down to zero bytes behaves like a nop.
                  if ((act_r == 2'b10) && (len_bytes_s != 17'd0)) begin
                     data_addr_r <= addr_lat_r;
                     remaining_r <= len_bytes_s;
                     state_r     <= ST_TFR;
                     xfer_req    <= 1'b1;
                     addr_RAM    <= addr_lat_r;
                  end else if (End_OUT) begin
                     state_r <= ST_STOP;
                     done    <= 1'b1;
                  end else begin
                     state_r   <= ST_FDS;
                     fetch_req <= 1'b1;
                     addr_RAM  <= next_ptr_s;
                  end
               end
               ST_TFR: begin
                  if (xfer_ack) begin
                     data_addr_r <= data_next_s;
                     remaining_r <= remaining_r - 17'd4;
                     if (remaining_r == 17'd4) begin
                        xfer_req <= 1'b0;
                        if (End_OUT) begin
                           state_r  <= ST_STOP;
                           done     <= 1'b1;
                           addr_RAM <= 64'd0;
                        end else begin
                           state_r   <= ST_FDS;
                           fetch_req <= 1'b1;
                           addr_RAM  <= desc_ptr_r;
                        end
                     end else begin
                        addr_RAM <= data_next_s;
                     end
                  end
               end
               default: begin
                  state_r <= ST_STOP;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dma_adma_ctrl.sv
// Bench for dma_adma_ctrl: descriptor vector table plus hand sequences for
// link chains, abort, error recovery and asynchronous reset.
module tb_dma_adma_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, abort, fetch_ack, xfer_ack;
   logic        valid_IN, End_IN, act1_IN, act2_IN;
   logic [15:0] len_IN;
   logic [63:0] desc_base, addr_COM;
   logic        fetch_req, xfer_req, valid_OUT, End_OUT, done, error;
   logic [63:0] addr_RAM;
   logic [1:0]  trans;

   dma_adma_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .desc_base(desc_base), .fetch_ack(fetch_ack),
      .valid_IN(valid_IN), .End_IN(End_IN), .act1_IN(act1_IN), .act2_IN(act2_IN),
      .len_IN(len_IN), .addr_COM(addr_COM), .xfer_ack(xfer_ack),
      .fetch_req(fetch_req), .xfer_req(xfer_req), .addr_RAM(addr_RAM),
      .valid_OUT(valid_OUT), .End_OUT(End_OUT), .trans(trans),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        endd;
      logic [1:0]  act;
      logic [15:0] len;
      logic [63:0] addr;
      logic        exp_err;
      logic        exp_done;
      logic [1:0]  exp_trans;
   } vec_t;

   vec_t        vt [9];
   vec_t        hd;
   logic [63:0] sb [$];
   int          tests = 0;
   int          fails = 0;
   logic [63:0] base;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; fetch_ack = 1'b0; xfer_ack = 1'b0;
      valid_IN = 1'b0; End_IN = 1'b0; act1_IN = 1'b0; act2_IN = 1'b0;
      len_IN = 16'd0; addr_COM = 64'd0; desc_base = 64'd0;
      sb.delete();
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_start(input logic [63:0] b);
      desc_base = b;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_trans", 64'(trans), 64'd1);
      chk("start_fetch_req", 64'(fetch_req), 64'd1);
      chk("start_addr", addr_RAM, b);
   endtask

   // Answer one fetch and queue the data addresses that descriptor must produce.
   task automatic serve(input vec_t v, input logic [63:0] exp_addr);
      int n = 0;
      int nb;
      while (!fetch_req && n < 20) begin
         step();
         n++;
      end
      chk("fetch_req_seen", 64'(fetch_req), 64'd1);
      chk("fetch_addr", addr_RAM, exp_addr);
      valid_IN = v.valid; End_IN = v.endd; act1_IN = v.act[0]; act2_IN = v.act[1];
      len_IN = v.len; addr_COM = v.addr; fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("fetch_req_drop", 64'(fetch_req), 64'd0);
      chk("valid_OUT", 64'(valid_OUT), 64'(v.valid));
      chk("End_OUT", 64'(End_OUT), 64'(v.endd));
      if (v.valid && v.act == 2'b10) begin
         nb = (v.len == 16'd0) ? 65536 : (int'(v.len) & ~3);
         for (int i = 0; i < nb / 4; i++) sb.push_back(v.addr + 64'(4 * i));
      end
   endtask

   // Acknowledge every data request, comparing its address against the queue.
   task automatic run_xfer();
      int n = 0;
      while (n < 70000) begin
         if (xfer_req) begin
            if (sb.size() > 0) chk("xfer_addr", addr_RAM, sb.pop_front());
            else chk("xfer_extra", 64'(xfer_req), 64'd0);
            xfer_ack = 1'b1;
         end else begin
            xfer_ack = 1'b0;
            if (trans != 2'b10) break;
         end
         step();
         n++;
      end
      xfer_ack = 1'b0;
      if (n >= 70000) chk("xfer_timeout", 64'd1, 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      vt[0] = '{1'b1, 1'b1, 2'b10, 16'd8,  64'h00000BBB00000000, 1'b0, 1'b1, 2'b00};
      vt[1] = '{1'b1, 1'b1, 2'b00, 16'd16, 64'h0000000000007000, 1'b0, 1'b1, 2'b00};
      vt[2] = '{1'b1, 1'b1, 2'b01, 16'd16, 64'h0000000000007000, 1'b0, 1'b1, 2'b00};
      vt[3] = '{1'b1, 1'b1, 2'b10, 16'd3,  64'h0000000000008000, 1'b0, 1'b1, 2'b00};
      vt[4] = '{1'b1, 1'b1, 2'b10, 16'd11, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1, 2'b00};
      vt[5] = '{1'b0, 1'b1, 2'b10, 16'd8,  64'h0000000000009000, 1'b1, 1'b0, 2'b00};
      vt[6] = '{1'b1, 1'b0, 2'b10, 16'd4,  64'h000000000000A000, 1'b0, 1'b0, 2'b01};
      vt[7] = '{1'b1, 1'b0, 2'b00, 16'd0,  64'h000000000000B000, 1'b0, 1'b0, 2'b01};
      vt[8] = '{1'b1, 1'b1, 2'b10, 16'd0,  64'h0000000050000000, 1'b0, 1'b1, 2'b00};

      do_reset();
      chk("rst_trans", 64'(trans), 64'd0);
      chk("rst_fetch_req", 64'(fetch_req), 64'd0);
      chk("rst_xfer_req", 64'(xfer_req), 64'd0);
      chk("rst_addr", addr_RAM, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_valid_OUT", 64'(valid_OUT), 64'd0);

      for (int i = 0; i < 9; i++) begin
         do_reset();
         base = 64'h1000 + 64'(i) * 64'h100;
         do_start(base);
         serve(vt[i], base);
         run_xfer();
         chk($sformatf("v%0d_trans", i), 64'(trans), 64'(vt[i].exp_trans));
         chk($sformatf("v%0d_done", i), 64'(done), 64'(vt[i].exp_done));
         chk($sformatf("v%0d_error", i), 64'(error), 64'(vt[i].exp_err));
         if (vt[i].exp_trans == 2'b01) chk($sformatf("v%0d_next_ptr", i), addr_RAM, base + 64'd16);
         step();
         chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
         chk($sformatf("v%0d_error_hold", i), 64'(error), 64'(vt[i].exp_err));
      end

      // Invalid descriptor, then a new start clears the sticky error.
      do_reset();
      do_start(64'h1200);
      hd = '{1'b0, 1'b0, 2'b00, 16'd4, 64'd0, 1'b0, 1'b0, 2'b00};
      serve(hd, 64'h1200);
      chk("inv_trans", 64'(trans), 64'd0);
      chk("inv_error", 64'(error), 64'd1);
      chk("inv_done", 64'(done), 64'd0);
      do_start(64'h1300);
      chk("inv_error_cleared", 64'(error), 64'd0);
      desc_base = 64'hDEAD0000;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ignored_addr", addr_RAM, 64'h1300);
      chk("start_ignored_trans", 64'(trans), 64'd1);

      // Link chain: second fetch comes from the link target.
      do_reset();
      do_start(64'h3000);
      hd = '{1'b1, 1'b0, 2'b11, 16'd0, 64'h2000, 1'b0, 1'b0, 2'b00};
      serve(hd, 64'h3000);
      run_xfer();
      chk("link_trans", 64'(trans), 64'd1);
      chk("link_addr", addr_RAM, 64'h2000);
      hd = '{1'b1, 1'b1, 2'b10, 16'd4, 64'hAAAA00, 1'b0, 1'b0, 2'b00};
      serve(hd, 64'h2000);
      run_xfer();
      chk("link_done", 64'(done), 64'd1);
      chk("link_end_trans", 64'(trans), 64'd0);

      // Abort after two acknowledged words.
      do_reset();
      do_start(64'h4000);
      hd = '{1'b1, 1'b1, 2'b10, 16'd16, 64'hC000, 1'b0, 1'b0, 2'b00};
      serve(hd, 64'h4000);
      step();
      for (int k = 0; k < 2; k++) begin
         chk("abort_xfer_req", 64'(xfer_req), 64'd1);
         chk("abort_xfer_addr", addr_RAM, sb.pop_front());
         xfer_ack = 1'b1;
         step();
      end
      xfer_ack = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      sb.delete();
      chk("abort_trans", 64'(trans), 64'd0);
      chk("abort_xfer_req_low", 64'(xfer_req), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_error", 64'(error), 64'd0);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_start_trans", 64'(trans), 64'd0);
      chk("abort_start_fetch", 64'(fetch_req), 64'd0);

      // Reset asserted between clock edges while a fetch is pending.
      do_start(64'h6000);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_fetch_req", 64'(fetch_req), 64'd0);
      chk("async_rst_trans", 64'(trans), 64'd0);
      chk("async_rst_addr", addr_RAM, 64'd0);
      chk("async_rst_valid_OUT", 64'(valid_OUT), 64'd0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_trans", 64'(trans), 64'd0);
      chk("post_rst_fetch_req", 64'(fetch_req), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
